text_buffer_writer: RTL

//  Writer side of the calculator text display. Accepts 4-bit calculator symbol codes over
//  a valid/ready handshake, maps each one to a 6-bit font ROM character address and writes
//  it into the display text RAM at a row/column cursor. The VGA picture generator reads

---
 rtl/text_buffer_writer_if.sv | 42 ++++
 rtl/text_buffer_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer_if.sv
// -----------------------------------------------------------------------------
// text_buffer_writer_if
// Groups the symbol handshake, the text RAM write port and the cursor and status
// outputs of the calculator text display writer.
//   master : symbol producer / observer (drives in_valid, in_code, clear)
//   slave  : text_buffer_writer (drives in_ready, wr_*, cursor_*, busy)
// Signals
//   in_valid    1       in_code is valid
//   in_code     4       calculator symbol code
//   in_ready    1       writer can accept a code this cycle
//   clear       1       single-cycle request to blank the screen
//   wr_en       1       text RAM write strobe
//   wr_addr     ADDR_W  text RAM address = row*COLS + col
//   wr_data     6       font ROM character address
//   cursor_col  7       current column
//   cursor_row  5       current row
//   busy        1       clear sweep in progress
// -----------------------------------------------------------------------------
interface text_buffer_writer_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [3:0]        in_code;
    logic              in_ready;
    logic              clear;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_data;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              busy;

    modport master (
        output in_valid, in_code, clear,
        input  in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );

    modport slave (
        input  in_valid, in_code, clear,
        output in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_buffer_writer.sv
// -----------------------------------------------------------------------------
// text_buffer_writer
// Writer side of the calculator text display. Accepts 4-bit symbol codes over a
// valid/ready handshake, maps each to a 6-bit font ROM character address and
// writes it into the text RAM at the row/column cursor. Also performs the
// full-screen clear sweep and cursor wrap-around.
// Ports
//   clk   in   system clock (shared with the VGA sync generator)
//   rst   in   synchronous, active-high reset
//   bus   text_buffer_writer_if.slave (handshake, RAM write port, cursor, busy)
// Parameters
//   COLS    characters per row
//   ROWS    character rows
//   ADDR_W  text RAM address width, 2**ADDR_W >= COLS*ROWS
// Configuration macro
//   TEXT_BUF_AUTOCLEAR_EN : when defined, wrapping the cursor from the last row
//   back to row 0 starts a clear sweep on the following cycle, as if clear had
//   been pulsed. Undefined (default): the wrap simply returns to (0,0).
// -----------------------------------------------------------------------------
module text_buffer_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    text_buffer_writer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [3:0]        CODE_NL   = 4'hf;
    localparam logic [5:0]        CHAR_SP   = 6'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
    logic [6:0]        col, col_nxt;
    logic [4:0]        row, row_nxt;

    logic              wr_en_p1, wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_p1, wr_addr_nxt;
    logic [5:0]        wr_data_p1, wr_data_nxt;

    logic              auto_pend;
    logic              clr_req;
    logic              in_ready;
    logic              accept;
    logic [ADDR_W-1:0] cur_addr;

    function automatic logic [5:0] sym_to_char(input logic [3:0] code);
        logic [5:0] ch;
        case (code)
            4'ha:    ch = 6'h2b;               // +
            4'hb:    ch = 6'h2d;               // -
            4'hc:    ch = 6'h2a;               // *
            4'hd:    ch = 6'h2f;               // /
            4'he:    ch = 6'h3d;               // =
            default: ch = 6'h30 + {2'b00, code}; // digits 0-9
        endcase
        return ch;
    endfunction

    // An automatic clear request behaves exactly like an external clear pulse.
    assign clr_req  = bus.clear | auto_pend;
    assign in_ready = (state == IDLE) & ~clr_req & ~rst;
    assign accept   = bus.in_valid & in_ready;
    assign cur_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

`ifdef TEXT_BUF_AUTOCLEAR_EN
    logic auto_nxt;

    always_ff @(posedge clk) begin
        if (rst) auto_pend <= 1'b0;
        else     auto_pend <= auto_nxt;
    end
`else
    assign auto_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        col_nxt      = col;
        row_nxt      = row;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr_p1;
        wr_data_nxt  = wr_data_p1;
`ifdef TEXT_BUF_AUTOCLEAR_EN
        auto_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt    = CLEAR;
                    clr_addr_nxt = '0;
                end else if (accept) begin
                    if (bus.in_code != CODE_NL) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cur_addr;
                        wr_data_nxt = sym_to_char(bus.in_code);
                    end
                    // Newline and end-of-row both drop to column 0 of the next row.
                    if (bus.in_code == CODE_NL || col == LAST_COL) begin
                        col_nxt = '0;
                        if (row == LAST_ROW) begin
                            row_nxt = '0;
`ifdef TEXT_BUF_AUTOCLEAR_EN
                            auto_nxt = 1'b1;
`endif
                        end else begin
                            row_nxt = row + 5'd1;
                        end
                    end else begin
                        col_nxt = col + 7'd1;
                    end
                end
            end
            CLEAR: begin
                if (bus.clear) begin
                    // Restart: drop this cycle's write so the next one is address 0.
                    clr_addr_nxt = '0;
                end else begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = clr_addr;
                    wr_data_nxt = CHAR_SP;
                    if (clr_addr == LAST_ADDR) begin
                        state_nxt = IDLE;
                        col_nxt   = '0;
                        row_nxt   = '0;
                    end else begin
                        clr_addr_nxt = clr_addr + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr   <= '0;
            col        <= '0;
            row        <= '0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            clr_addr   <= clr_addr_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            wr_en_p1   <= wr_en_nxt;
            wr_addr_p1 <= wr_addr_nxt;
            wr_data_p1 <= wr_data_nxt;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_p1;
    assign bus.wr_addr    = wr_addr_p1;
    assign bus.wr_data    = wr_data_p1;
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;
    assign bus.busy       = (state == CLEAR);

endmodule
